// File: rtl/mem_ring_pkg.sv
// Shared definitions for the memory-ring reply path.
//   FLIT_W        flit width (field slicing is fixed for 16)
//   MSG_W         packed reply message width: head(16) + addr(32) + data(128)
//   MAX_FLIT_IDX  index of the last flit of a full message
//   rep_state_e   reply-port FSM encodings, visible to the controller
//   FI_*          flit index of each message field
package mem_ring_pkg;

  localparam int unsigned FLIT_W = 16;
  localparam int unsigned MSG_W  = 176;

  localparam logic [3:0] MAX_FLIT_IDX = 4'd10;

  localparam logic [3:0] FI_HEAD    = 4'd0;
  localparam logic [3:0] FI_ADDR_HI = 4'd1;
  localparam logic [3:0] FI_ADDR_LO = 4'd2;
  localparam logic [3:0] FI_DATA0   = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAD = 2'b01,
    ST_BODY = 2'b10
  } rep_state_e;

  // Requested last-flit index, limited to a full message.
  function automatic logic [3:0] clamp_flit_max(input logic [3:0] req);
    return (req > MAX_FLIT_IDX) ? MAX_FLIT_IDX : req;
  endfunction

endpackage

// File: rtl/mem_rep_flit_sel.sv
// Combinational flit selector for the reply port.
//   msg_i   packed message {head, addr, data}
//   idx_i   flit index 0..MAX_FLIT_IDX
//   flit_o  selected 16-bit flit; out-of-range indices give 0
module mem_rep_flit_sel
  import mem_ring_pkg::*;
(
  input  logic [MSG_W-1:0]  msg_i,
  input  logic [3:0]        idx_i,
  output logic [FLIT_W-1:0] flit_o
);

  logic [15:0]  head;
  logic [31:0]  addr;
  logic [127:0] data;

  assign {head, addr, data} = msg_i;

  always_comb begin
    flit_o = '0;
    case (idx_i)
      FI_HEAD:    flit_o = head;
      FI_ADDR_HI: flit_o = addr[31:16];
      FI_ADDR_LO: flit_o = addr[15:0];
      default: begin
        // Data goes out most-significant word first.
        for (int k = 0; k < 8; k++) begin
          if (idx_i == FI_DATA0 + 4'(k)) flit_o = data[127 - 16*k -: 16];
        end
      end
    endcase
  end

endmodule

// File: rtl/mem_rep_out_port.sv
// Parallel-to-serial reply port downstream of the memory node controller.
// Captures one reply (head/addr/data + last-flit index) while IDLE and
// streams it as 16-bit flits under a valid/ready handshake.
//   clk, rst           clock, synchronous active-high reset
//   v_rep_out          message-valid pulse; accepted only in IDLE
//   head/addr/data_out_rep_out  message fields
//   en_flit_max_rep    qualifies flit_max_rep in the v_rep_out cycle
//   flit_max_rep       last flit index (clamped to 10; default 10)
//   m_rep_fsm_state    FSM state fed back to the controller
//   v_flit, flit_out, flit_tail, flit_rdy   flit stream handshake
//   rep_sent           pulse on the cycle the tail flit transfers
//   drop_err           sticky: v_rep_out seen while busy
//   flit_par           (MEM_REP_PORT_PARITY_EN only) XOR-reduce of flit_out
module mem_rep_out_port
  import mem_ring_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          v_rep_out,
  input  logic [15:0]   head_out_rep_out,
  input  logic [31:0]   addr_out_rep_out,
  input  logic [127:0]  data_out_rep_out,
  input  logic          en_flit_max_rep,
  input  logic [3:0]    flit_max_rep,
  output logic [1:0]    m_rep_fsm_state,
  output logic          v_flit,
  output logic [15:0]   flit_out,
  output logic          flit_tail,
  input  logic          flit_rdy,
  output logic          rep_sent,
  output logic          drop_err
`ifdef MEM_REP_PORT_PARITY_EN
  ,
  output logic          flit_par
`endif
);

  rep_state_e       state_q, state_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [3:0]       flit_max_q, flit_max_d;
  logic [3:0]       idx_q, idx_d;
  logic             drop_err_q, drop_err_d;
  logic             xfer;

  mem_rep_flit_sel u_flit_sel (
    .msg_i  (msg_q),
    .idx_i  (idx_q),
    .flit_o (flit_out)
  );

  // All flit-side outputs derive from registers, so they hold during a stall.
  assign v_flit          = (state_q == ST_HEAD) || (state_q == ST_BODY);
  assign flit_tail       = v_flit && (idx_q == flit_max_q);
  assign xfer            = v_flit && flit_rdy;
  assign rep_sent        = xfer && flit_tail;
  assign drop_err        = drop_err_q;
  assign m_rep_fsm_state = state_q;

`ifdef MEM_REP_PORT_PARITY_EN
  assign flit_par = ^flit_out;
`endif

  always_comb begin
    state_d    = state_q;
    msg_d      = msg_q;
    flit_max_d = flit_max_q;
    idx_d      = idx_q;
    drop_err_d = drop_err_q;

    if (v_rep_out && (state_q != ST_IDLE)) drop_err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (v_rep_out) begin
          msg_d      = {head_out_rep_out, addr_out_rep_out, data_out_rep_out};
          flit_max_d = en_flit_max_rep ? clamp_flit_max(flit_max_rep) : MAX_FLIT_IDX;
          idx_d      = FI_HEAD;
          state_d    = ST_HEAD;
        end
      end
      ST_HEAD, ST_BODY: begin
        if (xfer) begin
          if (flit_tail) begin
            idx_d   = FI_HEAD;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_BODY;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      msg_q      <= '0;
      flit_max_q <= '0;
      idx_q      <= '0;
      drop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      msg_q      <= msg_d;
      flit_max_q <= flit_max_d;
      idx_q      <= idx_d;
      drop_err_q <= drop_err_d;
    end
  end

endmodule

// File: tb/tb_mem_rep_out_port.sv
module tb_mem_rep_out_port;

  logic         clk;
  logic         rst;
  logic         v_rep_out;
  logic [15:0]  head_out_rep_out;
  logic [31:0]  addr_out_rep_out;
  logic [127:0] data_out_rep_out;
  logic         en_flit_max_rep;
  logic [3:0]   flit_max_rep;
  logic [1:0]   m_rep_fsm_state;
  logic         v_flit;
  logic [15:0]  flit_out;
  logic         flit_tail;
  logic         flit_rdy;
  logic         rep_sent;
  logic         drop_err;
`ifdef MEM_REP_PORT_PARITY_EN
  logic         flit_par;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc;
  logic [15:0] exp_f [11];

  mem_rep_out_port dut (
    .clk              (clk),
    .rst              (rst),
    .v_rep_out        (v_rep_out),
    .head_out_rep_out (head_out_rep_out),
    .addr_out_rep_out (addr_out_rep_out),
    .data_out_rep_out (data_out_rep_out),
    .en_flit_max_rep  (en_flit_max_rep),
    .flit_max_rep     (flit_max_rep),
    .m_rep_fsm_state  (m_rep_fsm_state),
    .v_flit           (v_flit),
    .flit_out         (flit_out),
    .flit_tail        (flit_tail),
    .flit_rdy         (flit_rdy),
    .rep_sent         (rep_sent),
    .drop_err         (drop_err)
`ifdef MEM_REP_PORT_PARITY_EN
    ,
    .flit_par         (flit_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample point: 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] head, input logic en, input logic [3:0] fm);
    head_out_rep_out = head;
    en_flit_max_rep  = en;
    flit_max_rep     = fm;
    v_rep_out        = 1'b1;
    step();
    v_rep_out        = 1'b0;
    en_flit_max_rep  = 1'b0;
    check("state_head_after_load", 32'(m_rep_fsm_state), 32'd1);
  endtask

  // Walk nfl flits with optional stall, in-flight drop attempt, or reset abort.
  task automatic run(input int nfl, input int stall_at, input int stall_len,
                     input int drop_at, input int abort_at, output int cycles);
    cycles = 0;
    for (int i = 0; i < nfl; i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_v_flit", 32'(v_flit), 32'd0);
        check("abort_state", 32'(m_rep_fsm_state), 32'd0);
        check("abort_rep_sent", 32'(rep_sent), 32'd0);
        return;
      end
      if (i == stall_at) begin
        flit_rdy = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          check("stall_flit_hold", 32'(flit_out), 32'(exp_f[i]));
          check("stall_no_sent", 32'(rep_sent), 32'd0);
          step();
          cycles++;
        end
        flit_rdy = 1'b1;
      end
      check("v_flit", 32'(v_flit), 32'd1);
      check("flit_out", 32'(flit_out), 32'(exp_f[i]));
      check("flit_tail", 32'(flit_tail), 32'(i == nfl - 1));
      check("rep_sent", 32'(rep_sent), 32'(i == nfl - 1));
`ifdef MEM_REP_PORT_PARITY_EN
      check("flit_par", 32'(flit_par), 32'(^exp_f[i]));
`endif
      if (i == 1) check("state_body", 32'(m_rep_fsm_state), 32'(nfl > 1 ? 2 : 0));
      if (i == drop_at) begin
        head_out_rep_out = 16'hDEAD;
        v_rep_out        = 1'b1;
      end
      step();
      v_rep_out = 1'b0;
      cycles++;
    end
    check("end_v_flit", 32'(v_flit), 32'd0);
    check("end_state_idle", 32'(m_rep_fsm_state), 32'd0);
  endtask

  initial begin
    exp_f = '{16'hA5A5, 16'h1234, 16'h5678, 16'h0011, 16'h2233, 16'h4455,
              16'h6677, 16'h8899, 16'hAABB, 16'hCCDD, 16'hEEFF};
    rst              = 1'b1;
    v_rep_out        = 1'b0;
    head_out_rep_out = '0;
    addr_out_rep_out = 32'h1234_5678;
    data_out_rep_out = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    en_flit_max_rep  = 1'b0;
    flit_max_rep     = '0;
    flit_rdy         = 1'b1;
    step();
    step();
    rst = 1'b0;

    check("rst_state", 32'(m_rep_fsm_state), 32'd0);
    check("rst_v_flit", 32'(v_flit), 32'd0);
    check("rst_flit_out", 32'(flit_out), 32'd0);
    check("rst_flit_tail", 32'(flit_tail), 32'd0);
    check("rst_rep_sent", 32'(rep_sent), 32'd0);
    check("rst_drop_err", 32'(drop_err), 32'd0);
`ifdef MEM_REP_PORT_PARITY_EN
    check("rst_flit_par", 32'(flit_par), 32'd0);
`endif

    // Full message, no backpressure.
    load(16'hA5A5, 1'b1, 4'd10);
    run(11, -1, 0, -1, -1, cyc);
    check("full_cycles", 32'(cyc), 32'd11);
    step();

    // Backpressure at flit 4 (data[111:96]).
    load(16'hA5A5, 1'b1, 4'd10);
    run(11, 4, 3, -1, -1, cyc);
    check("stall_cycles", 32'(cyc), 32'd14);
    step();

    // Head-only message.
    exp_f[0] = 16'h00C3;
    load(16'h00C3, 1'b1, 4'd0);
    run(1, -1, 0, -1, -1, cyc);
    check("headonly_cycles", 32'(cyc), 32'd1);
    step();

    // Clamp and default flit_max.
    exp_f[0] = 16'hA5A5;
    load(16'hA5A5, 1'b1, 4'd15);
    run(11, -1, 0, -1, -1, cyc);
    check("clamp_cycles", 32'(cyc), 32'd11);
    step();
    load(16'hA5A5, 1'b0, 4'd3);
    run(11, -1, 0, -1, -1, cyc);
    check("default_cycles", 32'(cyc), 32'd11);
    step();

    // Drop: second v_rep_out during BODY at flit 3.
    load(16'hA5A5, 1'b1, 4'd10);
    run(11, -1, 0, 3, -1, cyc);
    check("drop_err_set", 32'(drop_err), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("drop_no_second", 32'(v_flit), 32'd0);
      step();
    end
    check("drop_err_sticky", 32'(drop_err), 32'd1);

    // Reset mid-BODY at flit 5.
    load(16'hA5A5, 1'b1, 4'd10);
    run(11, -1, 0, -1, 5, cyc);
    check("abort_drop_err_clr", 32'(drop_err), 32'd0);
    step();
    check("abort_stays_idle", 32'(v_flit), 32'd0);

`ifdef MEM_REP_PORT_PARITY_EN
    exp_f[0] = 16'h0001;
    load(16'h0001, 1'b1, 4'd0);
    check("par_0001", 32'(flit_par), 32'd1);
    run(1, -1, 0, -1, -1, cyc);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
